// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed-by-unsigned divider.
//   div_state_t   : controller states
//   DIV_DW/DIV_VW : default dividend and divisor widths
//   DIV_CW        : step-counter width for the default dividend width
package div_pkg;

    localparam int unsigned DIV_DW = 8;
    localparam int unsigned DIV_VW = 4;
    localparam int unsigned DIV_CW = $clog2(DIV_DW + 1);

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StFixsign,
        StDone
    } div_state_t;

    // The counter must be able to hold the value DW itself.
    function automatic int unsigned div_cnt_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   part_rem : current partial remainder (VW+1 bits, always < divisor)
//   in_bit   : next dividend bit, MSB first
//   divisor  : unsigned divisor
//   next_rem : partial remainder after the step
//   q_bit    : quotient bit produced by the step
module div_step #(
    parameter int unsigned VW = 4
) (
    input  logic [VW:0]   part_rem,
    input  logic          in_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   next_rem,
    output logic          q_bit
);

    // One extra bit so a borrow shows up as a set MSB.
    logic [VW+1:0] trial;

    always_comb begin
        trial    = {part_rem, in_bit} - {2'b00, divisor};
        q_bit    = ~trial[VW+1];
        // part_rem < divisor, so the shifted value fits in VW+1 bits.
        next_rem = q_bit ? trial[VW:0] : {part_rem[VW-1:0], in_bit};
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle restoring divider: signed DW-bit dividend by unsigned VW-bit
// divisor, truncating quotient, remainder takes the sign of the dividend.
// Requires VW < DW.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (accepted only in IDLE)
//   dividend, divisor     : operands
//   out_valid / out_ready : result handshake (held in DONE until taken)
//   quotient, remainder   : result
//   div_by_zero           : divisor was zero (quotient = -1, remainder = dividend)
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int unsigned DW = DIV_DW,
    parameter int unsigned VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = div_cnt_width(DW);

    div_state_t    state_q, state_d;
    // mag_q starts as |dividend| and is shifted left each step; quotient bits
    // enter at the LSB, so after DW steps it holds the quotient magnitude.
    logic [DW-1:0] mag_q, mag_d;
    logic [VW:0]   part_q, part_d;
    logic [VW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   step_rem;
    logic          step_bit;

    div_step #(
        .VW(VW)
    ) u_step (
        .part_rem(part_q),
        .in_bit  (mag_q[DW-1]),
        .divisor (div_q),
        .next_rem(step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        part_d    = part_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    neg_d = dividend[DW-1];
                    // -2^(DW-1) negates to itself, which read unsigned is correct.
                    mag_d = dividend[DW-1] ? -dividend : dividend;
                    div_d = divisor;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = dividend;
                        state_d = StDone;
                    end else begin
                        part_d  = '0;
                        cnt_d   = CW'(DW);
                        state_d = StDivide;
                    end
                end
            end
            StDivide: begin
                part_d = step_rem;
                mag_d  = {mag_q[DW-2:0], step_bit};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = StFixsign;
                end
            end
            StFixsign: begin
                quot_d  = neg_q ? -mag_q : mag_q;
                rem_d   = neg_q ? -DW'(part_q) : DW'(part_q);
                state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mag_q   <= '0;
            part_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            part_q  <= part_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
